// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stage registers.
//   stage_state_t : occupancy state of one stage. The encoding equals the
//                   number of valid entries held, so it drives the
//                   occupancy output directly.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/flopr.sv
// Width-parametrised data register with synchronous reset and load enable.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears q to zero (priority over en)
//   en    : load d into q
//   d     : next value
//   q     : registered value
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register for any pipeline boundary.
// With SKID=1 a second (skid) entry lets in_ready depend on registered state
// only, while still sustaining one transfer per cycle. With SKID=0 the stage
// holds one entry and in_ready is combinational from out_ready.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high; empties the stage, zeroes data
//   flush     : synchronous kill of all held entries, beats any transfer
//   in_valid  : upstream presents in_data
//   in_ready  : stage can accept this cycle
//   in_data   : upstream payload
//   out_valid : main entry holds a valid payload
//   out_ready : downstream accepts this cycle
//   out_data  : main entry payload
//   occupancy : number of valid entries held (0..2)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit CLEAR_DATA = 1'b1,
  parameter bit SKID       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_t     state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_en, skid_en, main_from_skid;
  logic             data_clr;
  logic [WIDTH-1:0] main_q, main_d, skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);

  if (SKID) begin : g_ready_skid
    assign in_ready = (state_q != ST_FULL);
  end else begin : g_ready_single
    assign in_ready = ~out_valid | out_ready;
  end

  // Flush masks both fires, so a flushed entry is never counted as consumed
  // and no new payload is loaded.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready & ~flush;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire && SKID) begin
            // Downstream stalled: park the new word behind the main entry.
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign data_clr = reset | (flush & CLEAR_DATA);
  assign main_d   = main_from_skid ? skid_q : in_data;

  flopr #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (data_clr),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  if (SKID) begin : g_skid_reg
    flopr #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .reset (data_clr),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = '0;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Instance A: SKID=1, CLEAR_DATA=1
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [15:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_occupancy;

  // Instance B: SKID=0, CLEAR_DATA=0
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_occupancy;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(16), .CLEAR_DATA(1'b1), .SKID(1'b1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occupancy)
  );

  pipe_stage_elastic #(.WIDTH(16), .CLEAR_DATA(1'b0), .SKID(1'b0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted output is popped and compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_out_valid && a_out_ready && !a_flush) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_out", {16'h0, a_out_data}, 32'hFFFF_FFFF);
        end else begin
          $display("txn A: out=%h expected=%h", a_out_data, exp_a[0]);
          chk("a_out_order", {16'h0, a_out_data}, {16'h0, exp_a[0]});
          void'(exp_a.pop_front());
        end
      end
      if (b_out_valid && b_out_ready && !b_flush) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_out", {16'h0, b_out_data}, 32'hFFFF_FFFF);
        end else begin
          $display("txn B: out=%h expected=%h", b_out_data, exp_b[0]);
          chk("b_out_order", {16'h0, b_out_data}, {16'h0, exp_b[0]});
          void'(exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_data = 16'hBEEF;
    b_in_valid = 1'b1; b_in_data = 16'hBEEF;
    cyc();
    neg();
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_occ", a_occupancy, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_out_data", b_out_data, 0);
    cyc();
    reset = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    cyc();

    // ---------------- streaming ----------------
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'(i);
      exp_a.push_back(16'(i));
      neg();
      chk("stream_in_ready", a_in_ready, 1);
      chk("stream_occ_le1", a_occupancy <= 2'd1, 1);
      chk("stream_out_valid", a_out_valid, (i > 1));
      cyc();
    end
    a_in_valid = 1'b0;
    neg();
    chk("stream_last_valid", a_out_valid, 1);
    cyc();
    neg();
    chk("stream_drained", a_out_valid, 0);
    cyc();

    // ---------------- backpressure / skid ----------------
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h00A1; exp_a.push_back(16'h00A1);
    neg();
    chk("bp_rdy_a1", a_in_ready, 1);
    cyc();
    a_in_data = 16'h00A2; exp_a.push_back(16'h00A2);
    neg();
    chk("bp_rdy_a2", a_in_ready, 1);
    chk("bp_occ_one", a_occupancy, 1);
    cyc();
    a_in_data = 16'h00A3; exp_a.push_back(16'h00A3);
    neg();
    chk("bp_full_rdy", a_in_ready, 0);
    chk("bp_full_occ", a_occupancy, 2);
    chk("bp_full_head", a_out_data, 16'h00A1);
    cyc();
    neg();
    chk("bp_hold_rdy", a_in_ready, 0);
    cyc();
    a_out_ready = 1'b1;
    neg();
    chk("bp_drain1_valid", a_out_valid, 1);
    chk("bp_drain1_rdy", a_in_ready, 0);
    cyc();
    neg();
    chk("bp_drain2_data", a_out_data, 16'h00A2);
    chk("bp_drain2_rdy", a_in_ready, 1);
    cyc();
    a_in_valid = 1'b0;
    neg();
    chk("bp_drain3_data", a_out_data, 16'h00A3);
    chk("bp_drain3_occ", a_occupancy, 1);
    cyc();
    neg();
    chk("bp_empty_occ", a_occupancy, 0);
    cyc();

    // ---------------- flush while FULL ----------------
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h00B1; exp_a.push_back(16'h00B1);
    cyc();
    a_in_data = 16'h00B2; exp_a.push_back(16'h00B2);
    cyc();
    a_flush = 1'b1; a_in_data = 16'h0055;
    neg();
    chk("fl_pre_occ", a_occupancy, 2);
    exp_a.delete();
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    neg();
    chk("fl_occ", a_occupancy, 0);
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_out_data", a_out_data, 0);
    chk("fl_in_ready", a_in_ready, 1);
    cyc();
    neg();
    chk("fl_no_55", a_out_valid, 0);
    cyc();

    // ---------------- flush with out_ready=1 (CLEAR_DATA=1) ----------------
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h00C1; exp_a.push_back(16'h00C1);
    cyc();
    a_in_valid = 1'b0; a_flush = 1'b1; a_out_ready = 1'b1;
    neg();
    chk("flr_pre_valid", a_out_valid, 1);
    chk("flr_pre_data", a_out_data, 16'h00C1);
    exp_a.delete();
    cyc();
    a_flush = 1'b0;
    neg();
    chk("flr_valid", a_out_valid, 0);
    chk("flr_cleared", a_out_data, 0);
    cyc();

    // ---------------- SKID=0 instance ----------------
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h00D1; exp_b.push_back(16'h00D1);
    neg();
    chk("b_rdy_empty", b_in_ready, 1);
    cyc();
    b_in_data = 16'h00D2;
    #1;
    chk("b_rdy_blocked", b_in_ready, 0);
    chk("b_occ_one", b_occupancy, 1);
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy_comb", b_in_ready, 1);
    exp_b.push_back(16'h00D2);
    cyc();
    b_in_data = 16'h00D3; exp_b.push_back(16'h00D3);
    neg();
    chk("b_sustain_rdy1", b_in_ready, 1);
    chk("b_sustain_data1", b_out_data, 16'h00D2);
    cyc();
    b_in_data = 16'h00D4; exp_b.push_back(16'h00D4);
    neg();
    chk("b_sustain_rdy2", b_in_ready, 1);
    chk("b_sustain_data2", b_out_data, 16'h00D3);
    cyc();
    b_in_valid = 1'b0;
    neg();
    chk("b_sustain_data3", b_out_data, 16'h00D4);
    cyc();
    neg();
    chk("b_drained", b_out_valid, 0);
    cyc();

    // ---------------- flush with out_ready=1 (CLEAR_DATA=0) ----------------
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h00E1; exp_b.push_back(16'h00E1);
    neg();
    chk("b_fl_rdy", b_in_ready, 1);
    cyc();
    b_in_valid = 1'b0; b_flush = 1'b1; b_out_ready = 1'b1;
    neg();
    chk("b_fl_pre_valid", b_out_valid, 1);
    exp_b.delete();
    cyc();
    b_flush = 1'b0; b_out_ready = 1'b0;
    neg();
    chk("b_fl_valid", b_out_valid, 0);
    chk("b_fl_occ", b_occupancy, 0);
    chk("b_fl_retained", b_out_data, 16'h00E1);
    chk("b_fl_rdy_after", b_in_ready, 1);
    cyc();

    chk("a_sb_empty", exp_a.size(), 0);
    chk("b_sb_empty", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed enable/flush inter-stage registers: one generic stage register for any pipeline boundary (IF/ID, ID/EX, EX/MEM, ...).
- Replaces the global en/flush stall scheme with a valid/ready handshake.
- A skid entry keeps in_ready a pure function of registered state, so no combinational ready path runs upstream. Full throughput is one transfer per cycle.
- Synchronous flush turns the stage into a bubble; on flush, data can optionally be zeroed as a NOP.

Parameters:
WIDTH, 16, bit width of the payload bundle (all control + data fields concatenated by the instantiating stage)
CLEAR_DATA, 1, 1: flush/reset zero both data registers; 0: flush clears only valid state, data regs hold
SKID, 1, 1: two-entry (main + skid), in_ready registered; 0: single entry, in_ready = ~out_valid | out_ready (combinational)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock and synchronous active-high reset are fixed for this block
flush  input  1  synchronous kill of all held entries, priority over every transfer
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  main entry holds a valid payload
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  main entry payload
occupancy  output  2  number of valid entries held (0..2)

Behaviour:
- State (SKID=1): EMPTY(0 entries), ONE(main valid), FULL(main+skid valid). SKID=0: EMPTY/ONE only.
- in_fire = in_valid & in_ready & ~flush; out_fire = out_valid & out_ready & ~flush.
- out_valid = (state != EMPTY); out_data = main reg; occupancy = 0/1/2 per state.
- in_ready (SKID=1) = (state != FULL), from registered state only; stays 1 while flush is asserted unless FULL (input is discarded anyway).
- Transitions:
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire&out_fire -> ONE, main<=in_data. in_fire&~out_fire -> FULL, skid<=in_data (SKID=0: this cannot occur, in_ready=0). ~in_fire&out_fire -> EMPTY. Otherwise hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. No input is accepted.
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Latency: in_fire in EMPTY -> out_valid next cycle. Throughput is one per cycle with out_ready held high.
- Flush: next state EMPTY regardless of in_valid/out_ready. No transfer is counted that cycle, so the downstream must not consume out_data. CLEAR_DATA=1: main, skid <= 0.
- Reset: state EMPTY, main=skid=0 (irrespective of CLEAR_DATA); out_valid=0, occupancy=0, in_ready=1, out_data=0.
- Reset or flush mid-FULL loses both entries. This is intended: the owner replays from the PC.
- Data registers enable only on load; no toggling when idle.
- in_data must be stable only in a cycle where in_fire occurs. out_data is stable while out_valid&~out_ready.

Decomposition:
- Shared package pipe_pkg: typedef enum logic [1:0] stage_state_t {ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2}.
- Data storage reuses the existing flopr (parametrised width, sync reset, enable) for main and skid, with reset = reset | (flush & CLEAR_DATA).
- The control FSM stays inline. No new sub-module is needed.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in_data=16'hBEEF -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, send 16'h0001..16'h0008 back-to-back -> each appears one cycle later, 8 consecutive out_fire, occupancy never exceeds 1.
- Backpressure/skid: send 16'hA1, 16'hA2, 16'hA3 with out_ready=0 -> FULL after two accepts, in_ready=0, A3 is held upstream. Then out_ready=1 -> outputs A1, A2, A3 in order with no gaps.
- Flush while FULL, CLEAR_DATA=1, simultaneous in_valid=1 (16'h55) -> next cycle EMPTY, out_data=0, occupancy=0. 16'h55 is never output.
- Flush with out_ready=1 and out_valid=1 -> the entry is not counted as consumed and out_valid=0 next cycle. With CLEAR_DATA=0, out_data retains its prior value.
- SKID=0 instance: out_ready=0 with main valid -> in_ready=0 in the same cycle. Raising out_ready -> in_ready=1 combinationally, and a simultaneous in/out transfer is sustained.
